// File: rtl/pc_irq_pkg.sv
// Shared constants and the return-stack entry type for the PC / interrupt unit.
package pc_irq_pkg;
   localparam int                ADDR_W   = 27;
   localparam logic [ADDR_W-1:0] PC_START = 27'hC02522;
   localparam int                VEC_BASE = 1;
   localparam int                IRQ_ID_W = 4;

   typedef struct packed {
      logic [ADDR_W-1:0]   addr;
      logic [IRQ_ID_W-1:0] id;
   } stack_entry_t;
endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio_enc
   import pc_irq_pkg::*;
#(
   parameter int N_INT = 8
) (
   input  logic [N_INT-1:0]    req_i,
   output logic                valid_o,
   output logic [IRQ_ID_W-1:0] idx_o
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      for (int k = N_INT - 1; k >= 0; k--) begin
         if (req_i[k]) begin
            valid_o = 1'b1;
            idx_o   = IRQ_ID_W'(k);
         end
      end
   end

endmodule

// File: rtl/pc_irq_unit.sv
// Program counter with an N-channel vectored interrupt controller.
// Define PC_IRQ_NEST_EN for a nested LIFO return stack; default is one backup register.
module pc_irq_unit
   import pc_irq_pkg::*;
#(
   parameter int N_INT      = 8,
   parameter int NEST_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                step,
   input  logic                jump,
   input  logic                offset,
   input  logic [ADDR_W-1:0]   jump_addr,
   input  logic                reti,
   input  logic [N_INT-1:0]    irq,
   input  logic [N_INT-1:0]    irq_mask,
   output logic [ADDR_W-1:0]   pc_out,
   output logic [IRQ_ID_W-1:0] irq_id,
   output logic                irq_active,
   output logic [N_INT-1:0]    pending
);

   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [IRQ_ID_W-1:0] id_q, id_d;
   logic                active_q, active_d;
   logic [N_INT-1:0]    pend_q, pend_d;
   logic [N_INT-1:0]    prev_q;
   logic                step_q;

   logic                step_ev;
   logic [ADDR_W-1:0]   nxt;
   logic [ADDR_W-1:0]   vec;
   logic                cand_vld;
   logic [IRQ_ID_W-1:0] cand_idx;
   logic                in_app;
   logic                stk_has;
   logic                can_take;
   logic                do_pop;
   logic                do_take;
   logic [ADDR_W-1:0]   pop_addr;
   logic [N_INT-1:0]    clr;

   irq_prio_enc #(.N_INT(N_INT)) u_enc (
      .req_i   (pend_q & irq_mask),
      .valid_o (cand_vld),
      .idx_o   (cand_idx)
   );

   assign step_ev = step & ~step_q;
   assign nxt     = jump ? (offset ? pc_q + jump_addr : jump_addr) : pc_q + 1'b1;
   assign vec     = ADDR_W'(VEC_BASE) + ADDR_W'(cand_idx);
   assign in_app  = pc_q < PC_START;

`ifdef PC_IRQ_NEST_EN
   localparam int SP_W  = $clog2(NEST_DEPTH + 1);
   localparam int IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

   stack_entry_t        stack_q [NEST_DEPTH];
   logic [SP_W-1:0]     sp_q;
   logic [IDX_W-1:0]    push_idx;
   logic [IDX_W-1:0]    pop_idx;
   logic [IRQ_ID_W-1:0] pop_id;

   assign push_idx = IDX_W'(sp_q);
   assign pop_idx  = IDX_W'(sp_q - 1'b1);
   assign pop_addr = stack_q[pop_idx].addr;
   assign pop_id   = stack_q[pop_idx].id;
   assign stk_has  = sp_q != '0;
   // Preempt only a lower-priority (higher index) handler, and only with room to save it.
   assign can_take = cand_vld & in_app & (sp_q != SP_W'(NEST_DEPTH))
                   & (~active_q | (cand_idx < id_q));

   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q <= '0;
         for (int i = 0; i < NEST_DEPTH; i++) stack_q[i] <= '0;
      end else if (do_pop) begin
         sp_q <= sp_q - 1'b1;
      end else if (do_take) begin
         stack_q[push_idx] <= '{addr: nxt, id: id_q};
         sp_q              <= sp_q + 1'b1;
      end
   end
`else
   logic              int_en_q;
   logic [ADDR_W-1:0] bk_q;

   // int_en is low exactly while the backup register holds a return address.
   assign pop_addr = bk_q;
   assign stk_has  = ~int_en_q;
   assign can_take = cand_vld & in_app & int_en_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         int_en_q <= 1'b1;
         bk_q     <= '0;
      end else if (do_pop) begin
         int_en_q <= 1'b1;
      end else if (do_take) begin
         int_en_q <= 1'b0;
         bk_q     <= nxt;
      end
   end
`endif

   assign do_pop  = step_ev & reti & stk_has;
   assign do_take = step_ev & ~reti & can_take;

   always_comb begin
      pc_d     = pc_q;
      id_d     = id_q;
      active_d = active_q;
      clr      = '0;
      if (do_pop) begin
         pc_d = pop_addr;
`ifdef PC_IRQ_NEST_EN
         id_d     = pop_id;
         active_d = sp_q > SP_W'(1);
`else
         active_d = 1'b0;
`endif
      end else if (do_take) begin
         pc_d     = vec;
         id_d     = cand_idx;
         active_d = 1'b1;
         clr      = N_INT'(1) << cand_idx;
      end else if (step_ev) begin
         pc_d = nxt;
      end
      // A fresh edge in the same cycle as the clear keeps the channel pending.
      pend_d = (pend_q & ~clr) | (irq & ~prev_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= PC_START;
         id_q     <= '0;
         active_q <= 1'b0;
         pend_q   <= '0;
         prev_q   <= '0;
         step_q   <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         id_q     <= id_d;
         active_q <= active_d;
         pend_q   <= pend_d;
         prev_q   <= irq;
         step_q   <= step;
      end
   end

   assign pc_out     = pc_q;
   assign irq_id     = id_q;
   assign irq_active = active_q;
   assign pending    = pend_q;

endmodule

// File: tb/tb_pc_irq_unit.sv
// Bench for pc_irq_unit: queue-based reference model checked every cycle, plus directed literal checks.
module tb_pc_irq_unit;
   localparam int        AW    = 27;
   localparam int        NI    = 8;
   localparam int        DEPTH = 4;
   localparam logic [AW-1:0] START = 27'hC02522;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          step = 1'b0, jump = 1'b0, offset = 1'b0, reti = 1'b0;
   logic [AW-1:0] jump_addr = '0;
   logic [NI-1:0] irq = '0, irq_mask = '1;
   logic [AW-1:0] pc_out;
   logic [3:0]    irq_id;
   logic          irq_active;
   logic [NI-1:0] pending;

   int checks = 0;
   int errors = 0;

   pc_irq_unit #(.N_INT(NI), .NEST_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .step(step), .jump(jump), .offset(offset),
      .jump_addr(jump_addr), .reti(reti), .irq(irq), .irq_mask(irq_mask),
      .pc_out(pc_out), .irq_id(irq_id), .irq_active(irq_active), .pending(pending)
   );

   always #5 clk = ~clk;

   // Reference model
   typedef struct { logic [AW-1:0] a; int id; } ent_t;
   ent_t          stk[$];
   logic [AW-1:0] m_pc;
   int            m_id;
   bit            m_active, m_inten, m_stepprev, mvalid = 0;
   logic [NI-1:0] m_pend, m_prev;

   always @(posedge clk) begin
      logic [AW-1:0] nxt;
      logic [NI-1:0] clr;
      int            k;
      bit            ok;
      ent_t          e;
      if (reset) begin
         m_pc = START; m_id = 0; m_active = 0; m_inten = 1;
         m_pend = '0; m_prev = '0; m_stepprev = 0; stk.delete();
      end else begin
         clr = '0;
         if (step && !m_stepprev) begin
            if (jump) nxt = offset ? m_pc + jump_addr : jump_addr;
            else      nxt = m_pc + 1;
            if (reti) begin
               if (stk.size() > 0) begin
                  e = stk.pop_back();
                  m_pc = e.a;
`ifdef PC_IRQ_NEST_EN
                  m_id = e.id;
`endif
                  m_inten  = 1;
                  m_active = stk.size() > 0;
               end else m_pc = nxt;
            end else begin
               k = -1;
               for (int i = NI - 1; i >= 0; i--) if (m_pend[i] && irq_mask[i]) k = i;
`ifdef PC_IRQ_NEST_EN
               ok = (k >= 0) && (m_pc < START) && (stk.size() < DEPTH) && (!m_active || k < m_id);
`else
               ok = (k >= 0) && (m_pc < START) && m_inten;
`endif
               if (ok) begin
                  e.a = nxt; e.id = m_id;
                  stk.push_back(e);
                  m_pc = AW'(1 + k); m_id = k; clr[k] = 1'b1;
                  m_active = 1; m_inten = 0;
               end else m_pc = nxt;
            end
         end
         m_pend = (m_pend & ~clr) | (irq & ~m_prev);
         m_prev = irq;
         m_stepprev = step;
      end
      mvalid = 1;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mvalid) begin
         chk("m_pc", 32'(pc_out), 32'(m_pc));
         chk("m_id", 32'(irq_id), 32'(m_id[3:0]));
         chk("m_active", 32'(irq_active), 32'(m_active));
         chk("m_pend", 32'(pending), 32'(m_pend));
      end
   end

   task automatic tick(); @(negedge clk); endtask

   task automatic do_reset();
      reset = 1; step = 0; jump = 0; offset = 0; reti = 0; irq = '0; irq_mask = '1;
      tick(); tick(); reset = 0; tick();
   endtask

   task automatic do_step(input logic j, input logic o, input logic [AW-1:0] a, input logic r);
      step = 1; jump = j; offset = o; jump_addr = a; reti = r; tick();
      step = 0; jump = 0; offset = 0; reti = 0; tick();
   endtask

   task automatic pulse(input int k);
      irq[k] = 1'b1; tick(); irq[k] = 1'b0; tick();
   endtask

   initial begin
      tick(); tick();
      do_reset();
      // 1: reset state and plain advance
      chk("t1_pc0", 32'(pc_out), 32'h0C02522);
      chk("t1_id0", 32'(irq_id), 0);
      chk("t1_act0", 32'(irq_active), 0);
      chk("t1_pend0", 32'(pending), 0);
      do_step(0, 0, '0, 0); chk("t1_pc1", 32'(pc_out), 32'h0C02523);
      do_step(0, 0, '0, 0); chk("t1_pc2", 32'(pc_out), 32'h0C02524);
      do_step(0, 0, '0, 0); chk("t1_pc3", 32'(pc_out), 32'h0C02525);
      chk("t1_pend", 32'(pending), 0);

      // 2: single interrupt and return
      do_reset();
      do_step(1, 0, 27'h10, 0); chk("t2_pc10", 32'(pc_out), 32'h10);
      pulse(5); chk("t2_pend5", 32'(pending), 32'h20);
      do_step(0, 0, '0, 0);
      chk("t2_vec", 32'(pc_out), 6); chk("t2_id", 32'(irq_id), 5);
      chk("t2_act", 32'(irq_active), 1); chk("t2_clr", 32'(pending), 0);
      do_step(0, 0, '0, 1);
      chk("t2_ret", 32'(pc_out), 32'h11); chk("t2_act0", 32'(irq_active), 0);

      // 3: two simultaneous edges, lowest index first
      do_reset();
      do_step(1, 0, 27'h20, 0);
      irq = 8'h44; tick(); irq = '0; tick();
      do_step(0, 0, '0, 0);
      chk("t3_vec2", 32'(pc_out), 3); chk("t3_pend6", 32'(pending), 32'h40);
      do_step(0, 0, '0, 1); chk("t3_ret", 32'(pc_out), 32'h21);
      do_step(0, 0, '0, 0);
      chk("t3_vec6", 32'(pc_out), 7); chk("t3_id6", 32'(irq_id), 6);

      // 4: masked channel stays pending until unmasked
      do_reset();
      irq_mask = 8'hF7;
      do_step(1, 0, 27'h40, 0);
      pulse(3);
      do_step(0, 0, '0, 0);
      chk("t4_pc41", 32'(pc_out), 32'h41); chk("t4_pend3", 32'(pending), 32'h08);
      do_step(0, 0, '0, 0); chk("t4_pc42", 32'(pc_out), 32'h42);
      irq_mask = '1;
      do_step(0, 0, '0, 0);
      chk("t4_vec3", 32'(pc_out), 4); chk("t4_id3", 32'(irq_id), 3);

      // 5: boot ROM not interruptible; relative wrap
      do_reset();
      pulse(0);
      do_step(0, 0, '0, 0);
      chk("t5_rom", 32'(pc_out), 32'h0C02523); chk("t5_pend0", 32'(pending), 1);
      irq_mask = '0;
      do_step(1, 0, 27'h0, 0); chk("t5_pc0", 32'(pc_out), 0);
      do_step(1, 1, '1, 0); chk("t5_wrap", 32'(pc_out), 32'h7FFFFFF);
      chk("t5_pendk", 32'(pending), 1);

`ifdef PC_IRQ_NEST_EN
      // 6: nesting, LIFO return, reset mid-handler
      do_reset();
      do_step(1, 0, 27'h30, 0);
      pulse(4); do_step(0, 0, '0, 0); chk("t6_vec4", 32'(pc_out), 5);
      pulse(1); do_step(0, 0, '0, 0);
      chk("t6_vec1", 32'(pc_out), 2); chk("t6_id1", 32'(irq_id), 1);
      pulse(6); do_step(0, 0, '0, 0);
      chk("t6_hold6", 32'(pc_out), 3); chk("t6_pend6", 32'(pending), 32'h40);
      do_step(0, 0, '0, 1);
      chk("t6_ret1", 32'(pc_out), 6); chk("t6_id4", 32'(irq_id), 4);
      chk("t6_act", 32'(irq_active), 1);
      do_step(0, 0, '0, 1);
      chk("t6_ret2", 32'(pc_out), 32'h31); chk("t6_act0", 32'(irq_active), 0);
      do_step(0, 0, '0, 0); chk("t6_vec6", 32'(pc_out), 7);
      reset = 1; step = 1; tick(); step = 0; tick(); reset = 0; tick();
      chk("t6_rst_pc", 32'(pc_out), 32'h0C02522); chk("t6_rst_id", 32'(irq_id), 0);
      chk("t6_rst_act", 32'(irq_active), 0); chk("t6_rst_pend", 32'(pending), 0);
`else
      // Non-nested: a higher-priority edge inside a handler must wait for reti
      do_reset();
      do_step(1, 0, 27'h30, 0);
      pulse(4); do_step(0, 0, '0, 0); chk("t6_vec4", 32'(pc_out), 5);
      pulse(1); do_step(0, 0, '0, 0);
      chk("t6_nopre", 32'(pc_out), 6); chk("t6_pend1", 32'(pending), 2);
      do_step(0, 0, '0, 1); chk("t6_ret", 32'(pc_out), 32'h31);
      do_step(0, 0, '0, 0); chk("t6_vec1", 32'(pc_out), 2);
      reset = 1; step = 1; tick(); step = 0; tick(); reset = 0; tick();
      chk("t6_rst_pc", 32'(pc_out), 32'h0C02522); chk("t6_rst_act", 32'(irq_active), 0);
`endif

      // Randomized traffic, checked by the model every cycle
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         reset     = ($urandom_range(0, 299) == 0);
         step      = $urandom_range(0, 1);
         jump      = ($urandom_range(0, 9) < 3);
         offset    = $urandom_range(0, 1);
         jump_addr = ($urandom_range(0, 19) == 0) ? AW'($urandom) : AW'($urandom_range(0, 255));
         reti      = ($urandom_range(0, 9) < 2);
         if ($urandom_range(0, 3) == 0) irq = NI'($urandom);
         if ($urandom_range(0, 15) == 0) irq_mask = NI'($urandom | $urandom);
         tick();
      end
      reset = 0; step = 0; tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
